// File: rtl/piranha_pkg.sv
// Piranha combat shared types: FSM states, coordinates, hit-box sizes
// and the box-overlap helper used by the collision logic.
package piranha_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIVE,
    HURT,
    DYING,
    DEAD
  } state_e;

  localparam logic [10:0] PIR_W   = 11'd16;
  localparam logic [10:0] PIR_H   = 11'd32;
  localparam logic [10:0] MARIO_W = 11'd16;
  localparam logic [10:0] MARIO_H = 11'd16;
  localparam logic [10:0] FB_W    = 11'd8;
  localparam logic [10:0] FB_H    = 11'd8;

  // Strict inequalities: boxes that only share an edge do not collide
  function automatic logic overlap(
    input coord_t      ax,
    input coord_t      ay,
    input logic [10:0] aw,
    input logic [10:0] ah,
    input coord_t      bx,
    input coord_t      by,
    input logic [10:0] bw,
    input logic [10:0] bh
  );
    logic [10:0] ax1, ay1, bx1, by1;
    ax1 = {1'b0, ax};
    ay1 = {1'b0, ay};
    bx1 = {1'b0, bx};
    by1 = {1'b0, by};
    return (ax1 < bx1 + bw) && (bx1 < ax1 + aw) &&
           (ay1 < by1 + bh) && (by1 < ay1 + ah);
  endfunction

endpackage

// File: rtl/piranha_combat_if.sv
// Piranha combat bus: room/object positions in, combat status out.
interface piranha_combat_if;
  import piranha_pkg::*;

  logic [2:0] level_num;
  coord_t     piranha_x;
  coord_t     piranha_y;
  coord_t     mario_x;
  coord_t     mario_y;
  logic       fireball_active;
  coord_t     fireball_x;
  coord_t     fireball_y;
  logic       piranha_alive;
  logic [1:0] piranha_hp;
  logic       mario_hit;
  logic       fireball_consume;
  logic       score_add;
  logic       piranha_flash;

  modport master (
    output level_num, piranha_x, piranha_y,
    output mario_x, mario_y,
    output fireball_active, fireball_x, fireball_y,
    input  piranha_alive, piranha_hp, mario_hit,
    input  fireball_consume, score_add, piranha_flash
  );

  modport slave (
    input  level_num, piranha_x, piranha_y,
    input  mario_x, mario_y,
    input  fireball_active, fireball_x, fireball_y,
    output piranha_alive, piranha_hp, mario_hit,
    output fireball_consume, score_add, piranha_flash
  );

endinterface

// File: rtl/piranha_combat_frame_tick_sync.sv
// Brings the async frame strobe into the Clk domain and emits a
// registered one-cycle tick, three Clk edges after the strobe rises.
module frame_tick_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic tick_o
);

  logic s1_q, s2_q, s3_q, tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= s2_q & ~s3_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/piranha_combat.sv
// Piranha enemy combat FSM: hit points, invulnerability, death, respawn.
// Optional blink mask enabled by defining PIRANHA_BLINK_EN.
module piranha_combat
  import piranha_pkg::*;
#(
  parameter logic [2:0]  PIRANHA_LEVEL = 3'b011,
  parameter int unsigned MAX_HP        = 3,
  parameter int unsigned INVULN_FRAMES = 30,
  parameter int unsigned DYING_FRAMES  = 20
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  piranha_combat_if.slave bus
);

  localparam logic [1:0] HP_INIT = 2'(MAX_HP);
  localparam logic [5:0] INV_LD  = 6'(INVULN_FRAMES);
  localparam logic [5:0] DIE_LD  = 6'(DYING_FRAMES);

  logic       frame_tick;
  state_e     state_q, state_d;
  logic [1:0] hp_q, hp_d;
  logic [5:0] cnt_q, cnt_d, cnt_dec;
  logic       alive_q, alive_d;
  logic       mhit_q, mhit_d;
  logic       cons_q, cons_d;
  logic       score_q, score_d;
  logic       fb_ovl, m_ovl;

  frame_tick_sync u_sync (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .async_i(frame_clk),
    .tick_o (frame_tick)
  );

  assign fb_ovl = bus.fireball_active &
    overlap(bus.fireball_x, bus.fireball_y, FB_W, FB_H,
            bus.piranha_x, bus.piranha_y, PIR_W, PIR_H);
  assign m_ovl =
    overlap(bus.mario_x, bus.mario_y, MARIO_W, MARIO_H,
            bus.piranha_x, bus.piranha_y, PIR_W, PIR_H);

  assign cnt_dec = (cnt_q == 6'd0) ? 6'd0 : cnt_q - 6'd1;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    mhit_d  = 1'b0;
    cons_d  = 1'b0;
    score_d = 1'b0;
    if (frame_tick) begin
      if (bus.level_num != PIRANHA_LEVEL) begin
        state_d = IDLE;
        hp_d    = 2'd0;
        cnt_d   = 6'd0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d = ALIVE;
            hp_d    = HP_INIT;
          end
          ALIVE: begin
            mhit_d = m_ovl;
            // Fireball resolves first; a killing shot masks Mario's hit
            if (fb_ovl) begin
              cons_d = 1'b1;
              if (hp_q <= 2'd1) begin
                state_d = DYING;
                hp_d    = 2'd0;
                cnt_d   = DIE_LD;
                score_d = 1'b1;
                mhit_d  = 1'b0;
              end else begin
                state_d = HURT;
                hp_d    = hp_q - 2'd1;
                cnt_d   = INV_LD;
              end
            end
          end
          HURT: begin
            mhit_d = m_ovl;
            cnt_d  = cnt_dec;
            if (cnt_dec == 6'd0) state_d = ALIVE;
          end
          DYING: begin
            cnt_d = cnt_dec;
            if (cnt_dec == 6'd0) state_d = DEAD;
          end
          DEAD: state_d = DEAD;
          default: state_d = IDLE;
        endcase
      end
    end
    alive_d = (state_d == ALIVE) || (state_d == HURT) ||
              (state_d == DYING);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      hp_q    <= 2'd0;
      cnt_q   <= 6'd0;
      alive_q <= 1'b0;
      mhit_q  <= 1'b0;
      cons_q  <= 1'b0;
      score_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      alive_q <= alive_d;
      mhit_q  <= mhit_d;
      cons_q  <= cons_d;
      score_q <= score_d;
    end
  end

  assign bus.piranha_alive    = alive_q;
  assign bus.piranha_hp       = hp_q;
  assign bus.mario_hit        = mhit_q;
  assign bus.fireball_consume = cons_q;
  assign bus.score_add        = score_q;

`ifdef PIRANHA_BLINK_EN
  logic [1:0] blink_q, blink_d;
  logic       flash_q, flash_d;

  always_comb begin
    blink_d = blink_q;
    flash_d = flash_q;
    if (frame_tick) begin
      if (state_d == HURT || state_d == DYING) begin
        blink_d = blink_q + 2'd1;
        if (blink_q == 2'd3) flash_d = ~flash_q;
      end else begin
        blink_d = 2'd0;
        flash_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      blink_q <= 2'd0;
      flash_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      flash_q <= flash_d;
    end
  end

  assign bus.piranha_flash = flash_q;
`else
  assign bus.piranha_flash = 1'b0;
`endif

endmodule

// File: doc/piranha_combat.md
PIRANHA_COMBAT -- requirements
Module: piranha_combat

Interface
REQ-001 Parameter PIRANHA_LEVEL, default 3'b011: level in which the piranha is active.
REQ-002 Parameter MAX_HP, default 3: fireball hits needed to kill.
REQ-003 Parameter INVULN_FRAMES, default 30; parameter DYING_FRAMES, default 20.
REQ-004 Clk  input  1  system clock; the only clock.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 frame_clk  input  1  vertical-sync frame strobe; asynchronous to Clk.
REQ-007 level_num  input  3  current room number.
REQ-008 piranha_x, piranha_y  input  10 each  piranha top-left; sprite box 16x32.
REQ-009 mario_x, mario_y  input  10 each  Mario top-left; box 16x16.
REQ-010 fireball_active  input  1; fireball_x, fireball_y  input  10 each; fireball box 8x8.
REQ-011 piranha_alive  output  1  piranha is drawn and collidable.
REQ-012 piranha_hp  output  2  remaining hit points.
REQ-013 mario_hit  output  1  one-Clk pulse: Mario touched a live piranha.
REQ-014 fireball_consume  output  1  one-Clk pulse: fireball hit registered; fireball is removed.
REQ-015 score_add  output  1  one-Clk pulse on kill.
REQ-016 piranha_flash  output  1  blink mask for the colour mapper.

Function
REQ-017 frame_clk shall pass a 2-FF synchronizer plus a rising-edge detector, giving a one-Clk frame_tick 3 Clk cycles after the edge.
REQ-018 All collision evaluation and counter updates shall occur only on a frame_tick cycle; outputs shall be registered, with pulses asserted the Clk cycle after frame_tick.
REQ-019 Overlap of boxes A,B shall be ax < bx+BW and bx < ax+AW and ay < by+BH and by < ay+AH, computed at 11 bits; edge-touching is not overlap.
REQ-020 FSM states: IDLE, ALIVE, HURT, DYING, DEAD.
REQ-021 IDLE: piranha_alive=0. On a tick with level_num==PIRANHA_LEVEL, go to ALIVE with hp=MAX_HP.
REQ-022 ALIVE: fireball_active and a fireball overlap pulse fireball_consume and decrement hp. At hp reaching 0: go to DYING and pulse score_add. Otherwise: go to HURT with the counter loaded to INVULN_FRAMES.
REQ-023 HURT: fireball overlaps are ignored (no consume). The counter decrements per tick; at 0, return to ALIVE.
REQ-024 ALIVE and HURT: a Mario overlap pulses mario_hit every tick it persists.
REQ-025 Simultaneous fireball and Mario overlap on one tick: the fireball is evaluated first. If it kills, mario_hit is suppressed; otherwise both pulse.
REQ-026 DYING: piranha_alive=1, no collisions, counter from DYING_FRAMES. At 0, go to DEAD.
REQ-027 DEAD: piranha_alive=0. The piranha stays dead for the remainder of the room.
REQ-028 From any state, a tick with level_num!=PIRANHA_LEVEL shall force IDLE, hp=0, counter=0 (leaving and re-entering the room respawns the piranha).
REQ-029 The counter shall be 6 bits and shall saturate at 0; it shall never wrap.

Reset
REQ-030 While Reset=0: state=IDLE, hp=0, counter=0, synchronizer flops=0, and every output=0.
REQ-031 Reset asserted mid-HURT or mid-DYING shall abort immediately. No pulse shall be emitted on the first tick after release.

Configuration
REQ-032 Macro PIRANHA_BLINK_EN defined: piranha_flash toggles every 4 ticks in HURT and DYING, and is 0 elsewhere.
REQ-033 Macro PIRANHA_BLINK_EN undefined: piranha_flash is tied 0 and no blink logic is synthesized.

Structure
REQ-034 Package piranha_pkg shall hold: the state enum, the sprite/Mario/fireball box dimension constants, and the 10-bit coordinate typedef.
REQ-035 Sub-module frame_tick_sync shall hold the synchronizer and edge detector. All other logic stays in piranha_combat.

Verification
REQ-036 Enter level 3, fireball at (500,420) overlapping piranha (500,405): fireball_consume=1, hp 3->2, HURT held for 30 ticks.
REQ-037 Three spaced hits (after invulnerability expires): score_add=1 on the third, DYING for 20 ticks, then piranha_alive=0.
REQ-038 Mario at (516,405), edge-touching: no mario_hit. Mario at (515,405): mario_hit each tick.
REQ-039 Killing fireball and Mario overlap on the same tick: score_add=1, fireball_consume=1, mario_hit=0.
REQ-040 Switch to level 2 mid-HURT: IDLE next tick. Return to level 3: ALIVE with hp=3.
REQ-041 Reset=0 during DYING: all outputs 0 immediately; after release, IDLE and no pulses.
